// File: rtl/counter_updown_mod.sv
// counter_updown_mod: WIDTH-bit up/down counter with programmable modulus,
// synchronous clamped load, and wrap or saturate behaviour at the count bounds.
module counter_updown_mod #(
  parameter int unsigned     WIDTH    = 32'd4,
  parameter longint unsigned MODULUS  = 64'd16,
  parameter longint unsigned INIT     = 64'd0,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] O,
  output logic             TC,
  output logic             WRAP
);

  // Bounds are worked out in 64 bits so MODULUS-1 cannot overflow at WIDTH=32.
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(32'd0);

  if ((WIDTH < 32'd1) || (WIDTH > 32'd32)) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be in 1..32");
  end
  if ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("counter_updown_mod: MODULUS must be in 2..2^WIDTH");
  end
  if (INIT >= MODULUS) begin : g_bad_init
    $error("counter_updown_mod: INIT must be below MODULUS");
  end

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] next_count_s;
  logic             wrap_r;
  logic             next_wrap_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             at_bound_s;

  assign at_max_s   = (count_r == MAX_VAL);
  assign at_zero_s  = (count_r == ZERO_VAL);
  assign at_bound_s = UP ? at_max_s : at_zero_s;
  assign TC         = CE & at_bound_s;

  // Next-state selection: LOAD beats CE, CE beats hold; RESET is applied in the register.
  always_comb begin
    next_count_s = count_r;
    next_wrap_s  = 1'b0;
    if (LOAD) begin
      if (64'(LOAD_VAL) < MODULUS) begin
        next_count_s = LOAD_VAL;
      end else begin
        next_count_s = MAX_VAL;
      end
    end else if (CE) begin
      case ({UP, at_bound_s})
        2'b10:   next_count_s = count_r + ONE_VAL;
        2'b00:   next_count_s = count_r - ONE_VAL;
        2'b11, 2'b01: begin
          if (SATURATE) begin
            next_count_s = count_r;
          end else begin
            next_count_s = UP ? ZERO_VAL : MAX_VAL;
            next_wrap_s  = 1'b1;
          end
        end
        default: next_count_s = count_r;
      endcase
    end else begin
      next_count_s = count_r;
    end
  end

  // Count and wrap-pulse registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_r <= INIT_VAL;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= next_count_s;
      wrap_r  <= next_wrap_s;
    end
  end

  assign O    = count_r;
  assign WRAP = wrap_r;

endmodule
